// File: rtl/stream_width_conv_pkg.sv
// Mode encoding and width helpers shared by the stream width converter.
package stream_width_conv_pkg;

    localparam int BYTE_LEN = 8;

    typedef enum logic [1:0] {
        WCONV_PASS   = 2'd0,
        WCONV_PACK   = 2'd1,
        WCONV_UNPACK = 2'd2
    } wconv_mode_e;

    function automatic wconv_mode_e conv_mode(input int in_w, input int out_w);
        if (in_w < out_w) return WCONV_PACK;
        else if (in_w > out_w) return WCONV_UNPACK;
        else return WCONV_PASS;
    endfunction

    function automatic int conv_ratio(input int in_w, input int out_w);
        return (in_w > out_w) ? (in_w / out_w) : (out_w / in_w);
    endfunction

endpackage

// File: rtl/stream_width_conv_ctrl.sv
// Sub-word counter, end-of-stream tracking, handshake and overflow flag
// for stream_width_conv; the datapath only needs load/outclk/cnt.
module stream_width_conv_ctrl
    import stream_width_conv_pkg::*;
#(
    parameter wconv_mode_e MODE          = WCONV_UNPACK,
    parameter int          R             = 4,
    parameter bit          FLUSH_PARTIAL = 1'b1,
    parameter int          CW            = $clog2(R + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inclk,
    input  logic          in_done,
    input  logic          downstream_rdy,
    output logic          rdy,
    output logic          outclk,
    output logic          done,
    output logic          overflow,
    output logic          load,
    output logic [CW-1:0] cnt
);
    localparam logic [CW-1:0] FULL = CW'(R);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic pend_done;
    logic valid;
    logic partial;

    always_comb begin
        partial = (cnt != '0) && (cnt != FULL);
        if (MODE == WCONV_PACK) begin
            valid  = (cnt == FULL) || (FLUSH_PARTIAL && pend_done && partial);
            outclk = !rst && valid && downstream_rdy;
            rdy    = !pend_done && ((cnt != FULL) || outclk);
            done   = !rst && pend_done && ((cnt == '0) || outclk);
        end else begin
            valid  = (cnt != '0);
            outclk = !rst && valid && downstream_rdy;
            rdy    = !pend_done && ((cnt == '0) || ((cnt == ONE) && outclk));
            done   = !rst && pend_done && ((cnt == '0) || (outclk && (cnt == ONE)));
        end
        load = !rst && inclk && rdy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            pend_done <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (inclk && !rdy) overflow <= 1'b1;
            // in_done while already pending is absorbed; done always clears it
            pend_done <= done ? 1'b0 : (pend_done || in_done);
            if (MODE == WCONV_PACK) begin
                if (load) cnt <= outclk ? ONE : cnt + ONE;
                else if (outclk || (pend_done && partial && !FLUSH_PARTIAL)) cnt <= '0;
            end else begin
                if (load) cnt <= FULL;
                else if (outclk) cnt <= cnt - ONE;
            end
        end
    end

endmodule

// File: rtl/stream_width_conv.sv
// Parametrised stream width converter: packs, unpacks or passes words
// between IN_WIDTH and OUT_WIDTH with backpressure and end-of-stream flush.
module stream_width_conv
    import stream_width_conv_pkg::*;
#(
    parameter int IN_WIDTH      = 8,
    parameter int OUT_WIDTH     = 2,
    parameter bit LSB_FIRST     = 1'b1,
    parameter bit FLUSH_PARTIAL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inclk,
    input  logic [IN_WIDTH-1:0]  in,
    input  logic                 in_done,
    input  logic                 downstream_rdy,
    output logic                 rdy,
    output logic                 outclk,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 done,
    output logic                 overflow
);
    localparam wconv_mode_e MODE = conv_mode(IN_WIDTH, OUT_WIDTH);
    localparam int R  = conv_ratio(IN_WIDTH, OUT_WIDTH);
    localparam int BW = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
    localparam int CW = $clog2(R + 1);

    logic [BW-1:0] data_buf;
    logic [CW-1:0] cnt;
    logic          load;

    stream_width_conv_ctrl #(
        .MODE          (MODE),
        .R             (R),
        .FLUSH_PARTIAL (FLUSH_PARTIAL),
        .CW            (CW)
    ) u_ctrl (
        .clk            (clk),
        .rst            (rst),
        .inclk          (inclk),
        .in_done        (in_done),
        .downstream_rdy (downstream_rdy),
        .rdy            (rdy),
        .outclk         (outclk),
        .done           (done),
        .overflow       (overflow),
        .load           (load),
        .cnt            (cnt)
    );

    generate
        if (MODE == WCONV_PACK) begin : g_pack
            int gap;

            always_ff @(posedge clk) begin
                if (load) begin
                    if (LSB_FIRST) data_buf <= {in, data_buf[BW-1:IN_WIDTH]};
                    else           data_buf <= {data_buf[BW-IN_WIDTH-1:0], in};
                end
            end

            // Shifting out the unfilled slots discards stale bits and zero-pads a flushed partial word
            always_comb begin
                gap = (R - int'(cnt)) * IN_WIDTH;
                if (LSB_FIRST) out = data_buf >> gap;
                else           out = data_buf << gap;
            end
        end else begin : g_unpack
            logic unused_cnt;
            assign unused_cnt = ^cnt;

            always_ff @(posedge clk) begin
                if (load) begin
                    data_buf <= in;
                end else if (outclk) begin
                    if (LSB_FIRST) data_buf <= data_buf >> OUT_WIDTH;
                    else           data_buf <= data_buf << OUT_WIDTH;
                end
            end

            assign out = LSB_FIRST ? data_buf[OUT_WIDTH-1:0] : data_buf[BW-1:BW-OUT_WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_stream_width_conv.sv
// Directed bench for stream_width_conv: unpack table plus pack, flush,
// full-rate and mid-stream reset sequences on several configurations.
module tb_stream_width_conv;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // 8 -> 2 unpacker
    logic       a_inclk, a_idone, a_drdy;
    logic [7:0] a_in;
    logic       a_rdy, a_oclk, a_done, a_ovf;
    logic [1:0] a_out;

    stream_width_conv #(.IN_WIDTH(8), .OUT_WIDTH(2), .LSB_FIRST(1'b1), .FLUSH_PARTIAL(1'b1)) u_unp (
        .clk(clk), .rst(rst), .inclk(a_inclk), .in(a_in), .in_done(a_idone),
        .downstream_rdy(a_drdy), .rdy(a_rdy), .outclk(a_oclk), .out(a_out),
        .done(a_done), .overflow(a_ovf)
    );

    // 2 -> 8 packers sharing inputs: [0] LSB first flush, [1] MSB first flush, [2] LSB first discard
    logic       b_inclk, b_idone, b_drdy;
    logic [1:0] b_in;
    logic       b_rdy [3];
    logic       b_oclk [3];
    logic       b_done [3];
    logic       b_ovf [3];
    logic [7:0] b_out [3];

    stream_width_conv #(.IN_WIDTH(2), .OUT_WIDTH(8), .LSB_FIRST(1'b1), .FLUSH_PARTIAL(1'b1)) u_pk1 (
        .clk(clk), .rst(rst), .inclk(b_inclk), .in(b_in), .in_done(b_idone),
        .downstream_rdy(b_drdy), .rdy(b_rdy[0]), .outclk(b_oclk[0]), .out(b_out[0]),
        .done(b_done[0]), .overflow(b_ovf[0])
    );
    stream_width_conv #(.IN_WIDTH(2), .OUT_WIDTH(8), .LSB_FIRST(1'b0), .FLUSH_PARTIAL(1'b1)) u_pk0 (
        .clk(clk), .rst(rst), .inclk(b_inclk), .in(b_in), .in_done(b_idone),
        .downstream_rdy(b_drdy), .rdy(b_rdy[1]), .outclk(b_oclk[1]), .out(b_out[1]),
        .done(b_done[1]), .overflow(b_ovf[1])
    );
    stream_width_conv #(.IN_WIDTH(2), .OUT_WIDTH(8), .LSB_FIRST(1'b1), .FLUSH_PARTIAL(1'b0)) u_pkn (
        .clk(clk), .rst(rst), .inclk(b_inclk), .in(b_in), .in_done(b_idone),
        .downstream_rdy(b_drdy), .rdy(b_rdy[2]), .outclk(b_oclk[2]), .out(b_out[2]),
        .done(b_done[2]), .overflow(b_ovf[2])
    );

    // 8 -> 16 packer
    logic        c_inclk, c_idone, c_drdy;
    logic [7:0]  c_in;
    logic        c_rdy, c_oclk, c_done, c_ovf;
    logic [15:0] c_out;

    stream_width_conv #(.IN_WIDTH(8), .OUT_WIDTH(16), .LSB_FIRST(1'b1), .FLUSH_PARTIAL(1'b1)) u_wide (
        .clk(clk), .rst(rst), .inclk(c_inclk), .in(c_in), .in_done(c_idone),
        .downstream_rdy(c_drdy), .rdy(c_rdy), .outclk(c_oclk), .out(c_out),
        .done(c_done), .overflow(c_ovf)
    );

    typedef struct {
        logic        inclk;
        logic [15:0] din;
        logic        idone;
        logic        drdy;
        logic        rdy;
        logic        oclk;
        logic        chk_out;
        logic [15:0] dout;
        logic        done;
        logic        ovf;
    } vec_t;

    function automatic vec_t mk(input logic inclk, input logic [15:0] din, input logic idone,
                                input logic drdy, input logic rdy, input logic oclk,
                                input logic chk_out, input logic [15:0] dout,
                                input logic done, input logic ovf);
        vec_t v;
        v.inclk = inclk; v.din = din; v.idone = idone; v.drdy = drdy;
        v.rdy = rdy; v.oclk = oclk; v.chk_out = chk_out; v.dout = dout;
        v.done = done; v.ovf = ovf;
        return v;
    endfunction

    task automatic drive_a(input logic inclk, input logic [7:0] din, input logic idone, input logic drdy);
        @(negedge clk);
        a_inclk = inclk; a_in = din; a_idone = idone; a_drdy = drdy;
        #1;
    endtask

    task automatic drive_b(input logic inclk, input logic [1:0] din, input logic idone);
        @(negedge clk);
        b_inclk = inclk; b_in = din; b_idone = idone;
        #1;
    endtask

    task automatic drive_c(input logic inclk, input logic [7:0] din, input logic idone);
        @(negedge clk);
        c_inclk = inclk; c_in = din; c_idone = idone;
        #1;
    endtask

    vec_t a_tab[$];

    initial begin
        logic [7:0]  pk_exp [3];
        logic [1:0]  dib [4];
        logic [1:0]  unp_exp [4];
        logic [7:0]  byte_v;
        logic [7:0]  prev_byte;

        rst = 1'b1;
        a_inclk = 1'b0; a_in = '0; a_idone = 1'b0; a_drdy = 1'b1;
        b_inclk = 1'b0; b_in = '0; b_idone = 1'b0; b_drdy = 1'b1;
        c_inclk = 1'b0; c_in = '0; c_idone = 1'b0; c_drdy = 1'b1;

        // inclk, din, idone, drdy | rdy, oclk, chk_out, dout, done, ovf
        a_tab.push_back(mk(1, 16'hB4, 0, 1,  1, 0, 0, 0, 0, 0));
        a_tab.push_back(mk(0, 16'h00, 0, 1,  0, 1, 1, 0, 0, 0));
        a_tab.push_back(mk(0, 16'h00, 0, 1,  0, 1, 1, 1, 0, 0));
        a_tab.push_back(mk(0, 16'h00, 0, 1,  0, 1, 1, 3, 0, 0));
        a_tab.push_back(mk(1, 16'h1B, 0, 1,  1, 1, 1, 2, 0, 0));
        a_tab.push_back(mk(0, 16'h00, 0, 1,  0, 1, 1, 3, 0, 0));
        a_tab.push_back(mk(1, 16'hFF, 0, 0,  0, 0, 0, 0, 0, 0));
        a_tab.push_back(mk(0, 16'h00, 0, 0,  0, 0, 0, 0, 0, 1));
        a_tab.push_back(mk(0, 16'h00, 0, 1,  0, 1, 1, 2, 0, 1));
        a_tab.push_back(mk(0, 16'h00, 0, 0,  0, 0, 0, 0, 0, 1));
        a_tab.push_back(mk(0, 16'h00, 0, 0,  0, 0, 0, 0, 0, 1));
        a_tab.push_back(mk(0, 16'h00, 0, 1,  0, 1, 1, 1, 0, 1));
        a_tab.push_back(mk(0, 16'h00, 0, 1,  1, 1, 1, 0, 0, 1));
        a_tab.push_back(mk(1, 16'h9C, 1, 1,  1, 0, 0, 0, 0, 1));
        a_tab.push_back(mk(0, 16'h00, 0, 1,  0, 1, 1, 0, 0, 1));
        a_tab.push_back(mk(0, 16'h00, 0, 1,  0, 1, 1, 3, 0, 1));
        a_tab.push_back(mk(0, 16'h00, 0, 1,  0, 1, 1, 1, 0, 1));
        a_tab.push_back(mk(0, 16'h00, 0, 1,  0, 1, 1, 2, 1, 1));
        a_tab.push_back(mk(0, 16'h00, 0, 1,  1, 0, 0, 0, 0, 1));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset unp rdy", a_rdy, 1);
        check("reset unp outclk", a_oclk, 0);
        check("reset unp done", a_done, 0);
        check("reset unp overflow", a_ovf, 0);
        check("reset pack rdy", b_rdy[0], 1);
        check("reset pack outclk", b_oclk[0], 0);
        check("reset wide rdy", c_rdy, 1);
        check("reset wide overflow", c_ovf, 0);

        foreach (a_tab[i]) begin
            drive_a(a_tab[i].inclk, a_tab[i].din[7:0], a_tab[i].idone, a_tab[i].drdy);
            check($sformatf("unp[%0d] rdy", i), a_rdy, a_tab[i].rdy);
            check($sformatf("unp[%0d] outclk", i), a_oclk, a_tab[i].oclk);
            check($sformatf("unp[%0d] done", i), a_done, a_tab[i].done);
            check($sformatf("unp[%0d] overflow", i), a_ovf, a_tab[i].ovf);
            if (a_tab[i].chk_out) check($sformatf("unp[%0d] out", i), a_out, a_tab[i].dout);
        end

        // reset with two sub-words still buffered
        drive_a(1, 8'hB4, 0, 1);
        drive_a(0, 8'h00, 0, 1);
        check("rst seq out0", a_out, 0);
        drive_a(0, 8'h00, 0, 1);
        check("rst seq out1", a_out, 1);
        @(negedge clk);
        a_inclk = 1'b0;
        rst = 1'b1;
        #1;
        check("in rst outclk", a_oclk, 0);
        check("in rst done", a_done, 0);
        @(negedge clk);
        rst = 1'b0;
        a_inclk = 1'b1; a_in = 8'h1B;
        #1;
        check("post rst outclk", a_oclk, 0);
        check("post rst rdy", a_rdy, 1);
        check("post rst overflow", a_ovf, 0);
        check("post rst done", a_done, 0);
        unp_exp[0] = 2'd3; unp_exp[1] = 2'd2; unp_exp[2] = 2'd1; unp_exp[3] = 2'd0;
        for (int i = 0; i < 4; i++) begin
            drive_a(0, 8'h00, 0, 1);
            check($sformatf("post rst outclk%0d", i), a_oclk, 1);
            check($sformatf("post rst out%0d", i), a_out, unp_exp[i]);
            check($sformatf("post rst done%0d", i), a_done, 0);
        end
        drive_a(0, 8'h00, 0, 1);
        check("post rst drained", a_oclk, 0);

        // full pack of 0,1,3,2
        dib[0] = 2'd0; dib[1] = 2'd1; dib[2] = 2'd3; dib[3] = 2'd2;
        for (int i = 0; i < 4; i++) begin
            drive_b(1, dib[i], 0);
            for (int k = 0; k < 3; k++) begin
                check($sformatf("pack%0d in%0d rdy", k, i), b_rdy[k], 1);
                check($sformatf("pack%0d in%0d outclk", k, i), b_oclk[k], 0);
            end
        end
        pk_exp[0] = 8'hB4; pk_exp[1] = 8'h1E; pk_exp[2] = 8'hB4;
        drive_b(0, 2'd0, 0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("pack%0d full outclk", k), b_oclk[k], 1);
            check($sformatf("pack%0d full out", k), b_out[k], pk_exp[k]);
            check($sformatf("pack%0d full done", k), b_done[k], 0);
        end
        drive_b(0, 2'd0, 0);
        for (int k = 0; k < 3; k++) check($sformatf("pack%0d after outclk", k), b_oclk[k], 0);

        // partial word 3,1 then in_done
        drive_b(1, 2'd3, 0);
        drive_b(1, 2'd1, 0);
        drive_b(0, 2'd0, 1);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("pack%0d partial outclk", k), b_oclk[k], 0);
            check($sformatf("pack%0d partial done", k), b_done[k], 0);
        end
        drive_b(0, 2'd0, 0);
        check("flush lsb outclk", b_oclk[0], 1);
        check("flush lsb out", b_out[0], 8'h07);
        check("flush lsb done", b_done[0], 1);
        check("flush msb outclk", b_oclk[1], 1);
        check("flush msb out", b_out[1], 8'hD0);
        check("flush msb done", b_done[1], 1);
        check("discard outclk", b_oclk[2], 0);
        check("discard done early", b_done[2], 0);
        check("discard rdy pending", b_rdy[2], 0);
        drive_b(0, 2'd0, 0);
        check("flush lsb done cleared", b_done[0], 0);
        check("flush lsb rdy back", b_rdy[0], 1);
        check("discard outclk late", b_oclk[2], 0);
        check("discard done", b_done[2], 1);
        drive_b(0, 2'd0, 0);
        check("discard done cleared", b_done[2], 0);
        check("discard rdy back", b_rdy[2], 1);

        // in_done on an empty buffer
        drive_b(0, 2'd0, 1);
        check("empty done early", b_done[0], 0);
        drive_b(0, 2'd0, 0);
        check("empty done", b_done[0], 1);
        check("empty outclk", b_oclk[0], 0);
        drive_b(0, 2'd0, 0);
        check("empty done cleared", b_done[0], 0);

        // 8 -> 16 at full input rate, in_done with the last byte
        prev_byte = 8'h00;
        for (int i = 0; i < 6; i++) begin
            byte_v = 8'(8'h11 * (i + 1));
            drive_c(1, byte_v, (i == 5));
            check($sformatf("wide in%0d rdy", i), c_rdy, 1);
            check($sformatf("wide in%0d outclk", i), c_oclk, (i == 2 || i == 4));
            if (i == 2 || i == 4) begin
                check($sformatf("wide in%0d out", i), c_out, {prev_byte, 8'(prev_byte - 8'h11)});
            end
            check($sformatf("wide in%0d done", i), c_done, 0);
            prev_byte = byte_v;
        end
        drive_c(0, 8'h00, 0);
        check("wide last outclk", c_oclk, 1);
        check("wide last out", c_out, 16'h6655);
        check("wide last done", c_done, 1);
        check("wide last rdy", c_rdy, 0);
        drive_c(0, 8'h00, 0);
        check("wide idle done", c_done, 0);
        check("wide idle rdy", c_rdy, 1);
        check("wide overflow", c_ovf, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
